// File: rtl/cmd_snd.sv
// Remote-side command initiator: sends opcode, data[15:8], data[7:0] over a byte UART, then waits for a response byte.
// Build option: define CMD_RETRY_EN to retransmit the frame on timeout (3 attempts total).
module cmd_snd #(
  parameter int unsigned TMO_CYCLES = 1000000,
  parameter bit          FAST_SIM   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        snd_cmd,
  input  logic [7:0]  cmd,
  input  logic [15:0] data,
  output logic [7:0]  tx_data,
  output logic        trmt,
  input  logic        tx_done,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  output logic        clr_rx_rdy,
  output logic [7:0]  resp,
  output logic        resp_rdy,
  output logic        tmo,
  output logic        busy
);

  localparam int unsigned LIMIT = FAST_SIM ? 1024 : TMO_CYCLES;
  localparam logic [19:0] TERM  = 20'(LIMIT - 1);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_TX, WAIT_RESP} state_t;

  state_t      state;
  logic [23:0] shadow;
  logic [1:0]  bcnt;
  logic [19:0] timer;
`ifdef CMD_RETRY_EN
  logic [1:0]  attempt;
`endif

  function automatic logic [7:0] frame_byte(input logic [23:0] frm, input logic [1:0] idx);
    case (idx)
      2'd0:    return frm[23:16];
      2'd1:    return frm[15:8];
      default: return frm[7:0];
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shadow     <= '0;
      bcnt       <= '0;
      timer      <= '0;
      tx_data    <= '0;
      trmt       <= 1'b0;
      clr_rx_rdy <= 1'b0;
      resp       <= '0;
      resp_rdy   <= 1'b0;
      tmo        <= 1'b0;
      busy       <= 1'b0;
`ifdef CMD_RETRY_EN
      attempt    <= '0;
`endif
    end else begin
      trmt <= 1'b0;
      // Any held byte is knocked down, but never on back-to-back cycles so rx_rdy has time to fall.
      clr_rx_rdy <= rx_rdy & ~clr_rx_rdy;
      case (state)
        IDLE: begin
          if (snd_cmd) begin
            shadow   <= {cmd, data};
            resp_rdy <= 1'b0;
            tmo      <= 1'b0;
            bcnt     <= '0;
            tx_data  <= cmd;
            trmt     <= 1'b1;
            busy     <= 1'b1;
            state    <= LOAD;
`ifdef CMD_RETRY_EN
            attempt  <= '0;
`endif
          end
        end
        LOAD: state <= WAIT_TX;
        WAIT_TX: begin
          if (tx_done) begin
            if (bcnt != 2'd2) begin
              bcnt    <= bcnt + 2'd1;
              tx_data <= frame_byte(shadow, bcnt + 2'd1);
              trmt    <= 1'b1;
              state   <= LOAD;
            end else begin
              timer <= '0;
              state <= WAIT_RESP;
            end
          end
        end
        WAIT_RESP: begin
          if (timer != '1) timer <= timer + 20'd1;
          // A byte arriving on the terminal-count cycle still counts as a response.
          if (rx_rdy && !clr_rx_rdy) begin
            resp     <= rx_data;
            resp_rdy <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end else if (timer == TERM) begin
`ifdef CMD_RETRY_EN
            if (attempt != 2'd2) begin
              attempt <= attempt + 2'd1;
              bcnt    <= '0;
              tx_data <= shadow[23:16];
              trmt    <= 1'b1;
              state   <= LOAD;
            end else begin
              tmo   <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end
`else
            tmo   <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
